// File: rtl/trap_seq.sv
// -----------------------------------------------------------------------------
// trap_seq -- trap/interrupt entry sequencer.
//
// Takes over the datapath at an instruction boundary when an exception,
// a software INT or an enabled hardware interrupt is pending. It then steps
// through: push PC, optionally push the cause word, and load the PC from the
// trap vector. On that last step it also switches to supervisor mode and,
// for everything except faults, clears the global interrupt mask.
//
// Parameters
//   NUM_IRQ    number of hardware interrupt lines (1..16)
//   EDGE       1: irq lines are rising-edge latched, 0: level-sensitive
//   VEC_BASE   vector of irq[0]; swint uses VEC_BASE+NUM_IRQ and
//              except uses VEC_BASE+NUM_IRQ+1
//   PUSH_CAUSE 1: push the cause word after the PC
//
// Ports
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   irq, irq_en    hardware requests and per-line enables
//   imask          global interrupt enable
//   boundary       CU is in FETCH, so a trap may be accepted now
//   swint, except  software INT / fault; looked at only with boundary
//   busy           sequencer owns the datapath
//   push_pc        push PC this cycle
//   push_cause     push cause word this cycle
//   ld_pc_vec      load PC from vec this cycle
//   vec, cause     vector and cause latched when the trap is accepted
//   ld_imask       clear imask this cycle
//   ld_mode        enter supervisor mode this cycle
//   irq_ack        one-hot acknowledge of the serviced hw line
// -----------------------------------------------------------------------------
module trap_seq #(
  parameter int          NUM_IRQ    = 4,
  parameter bit          EDGE       = 1'b0,
  parameter logic [31:0] VEC_BASE   = 32'd1,
  parameter bit          PUSH_CAUSE = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               imask,
  input  logic               boundary,
  input  logic               swint,
  input  logic               except,
  output logic               busy,
  output logic               push_pc,
  output logic               push_cause,
  output logic               ld_pc_vec,
  output logic [31:0]        vec,
  output logic [7:0]         cause,
  output logic               ld_imask,
  output logic               ld_mode,
  output logic [NUM_IRQ-1:0] irq_ack
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PUSH_PC    = 2'd1,
    ST_PUSH_CAUSE = 2'd2,
    ST_VECTOR     = 2'd3
  } state_e;

  // Cause type field encodings.
  localparam logic [1:0] TYPE_HW  = 2'b01;
  localparam logic [1:0] TYPE_SW  = 2'b10;
  localparam logic [1:0] TYPE_EXC = 2'b11;

  // One-hot decode of a hardware line number.
  function automatic logic [NUM_IRQ-1:0] line_onehot(input logic [3:0] line);
    logic [NUM_IRQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      v[i] = (line == 4'(i));
    end
    return v;
  endfunction

  state_e             state_q;
  logic               busy_q;
  logic               push_pc_q;
  logic               push_cause_q;
  logic               ld_pc_vec_q;
  logic               ld_imask_q;
  logic               ld_mode_q;
  logic [NUM_IRQ-1:0] irq_ack_q;
  logic [31:0]        vec_q;
  logic [7:0]         cause_q;
  // Ack pattern and imask-clear decision held from acceptance until VECTOR.
  logic [NUM_IRQ-1:0] ack_line_q;
  logic               imask_clr_q;

  logic [NUM_IRQ-1:0] pending_s;
  logic [NUM_IRQ-1:0] hw_elig_s;
  logic               accept_s;
  logic [3:0]         hw_line_s;
  logic [31:0]        vec_d;
  logic [7:0]         cause_d;
  logic [NUM_IRQ-1:0] ack_d;
  logic               imask_clr_d;

  generate
    if (EDGE) begin : g_edge
      logic [NUM_IRQ-1:0] irq_prev_q;
      logic [NUM_IRQ-1:0] pending_q;

      // Edge history and sticky pending bits; a fresh edge beats the ack clear.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          irq_prev_q <= '0;
          pending_q  <= '0;
        end else begin
          irq_prev_q <= irq;
          pending_q  <= (pending_q & ~irq_ack_q) | (irq & ~irq_prev_q);
        end
      end

      assign pending_s = pending_q;
    end else begin : g_level
      assign pending_s = irq;
    end
  endgenerate

  // Eligibility, priority arbitration and vector/cause selection.
  always_comb begin
    hw_elig_s   = pending_s & irq_en & {NUM_IRQ{imask}};
    accept_s    = boundary & (except | swint | (|hw_elig_s));
    // Scan from the top so the lowest eligible index is the last one written.
    hw_line_s   = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      hw_line_s = hw_elig_s[i] ? 4'(i) : hw_line_s;
    end
    vec_d       = 32'd0;
    cause_d     = 8'd0;
    ack_d       = '0;
    imask_clr_d = 1'b0;
    if (except) begin
      vec_d       = VEC_BASE + 32'(NUM_IRQ) + 32'd1;
      cause_d     = {TYPE_EXC, 6'd0};
      ack_d       = '0;
      imask_clr_d = 1'b0;
    end else if (swint) begin
      vec_d       = VEC_BASE + 32'(NUM_IRQ);
      cause_d     = {TYPE_SW, 6'd0};
      ack_d       = '0;
      imask_clr_d = 1'b1;
    end else begin
      vec_d       = VEC_BASE + {28'd0, hw_line_s};
      cause_d     = {TYPE_HW, 2'b00, hw_line_s};
      ack_d       = line_onehot(hw_line_s);
      imask_clr_d = 1'b1;
    end
  end

  // Trap entry FSM; every strobe is a registered one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      push_pc_q    <= 1'b0;
      push_cause_q <= 1'b0;
      ld_pc_vec_q  <= 1'b0;
      ld_imask_q   <= 1'b0;
      ld_mode_q    <= 1'b0;
      irq_ack_q    <= '0;
      vec_q        <= 32'd0;
      cause_q      <= 8'd0;
      ack_line_q   <= '0;
      imask_clr_q  <= 1'b0;
    end else begin
      push_pc_q    <= 1'b0;
      push_cause_q <= 1'b0;
      ld_pc_vec_q  <= 1'b0;
      ld_imask_q   <= 1'b0;
      ld_mode_q    <= 1'b0;
      irq_ack_q    <= '0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q     <= ST_PUSH_PC;
            busy_q      <= 1'b1;
            push_pc_q   <= 1'b1;
            vec_q       <= vec_d;
            cause_q     <= cause_d;
            ack_line_q  <= ack_d;
            imask_clr_q <= imask_clr_d;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_PUSH_PC: begin
          busy_q <= 1'b1;
          if (PUSH_CAUSE) begin
            state_q      <= ST_PUSH_CAUSE;
            push_cause_q <= 1'b1;
          end else begin
            state_q     <= ST_VECTOR;
            ld_pc_vec_q <= 1'b1;
            ld_mode_q   <= 1'b1;
            ld_imask_q  <= imask_clr_q;
            irq_ack_q   <= ack_line_q;
          end
        end
        ST_PUSH_CAUSE: begin
          busy_q      <= 1'b1;
          state_q     <= ST_VECTOR;
          ld_pc_vec_q <= 1'b1;
          ld_mode_q   <= 1'b1;
          ld_imask_q  <= imask_clr_q;
          irq_ack_q   <= ack_line_q;
        end
        ST_VECTOR: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign push_pc    = push_pc_q;
  assign push_cause = push_cause_q;
  assign ld_pc_vec  = ld_pc_vec_q;
  assign vec        = vec_q;
  assign cause      = cause_q;
  assign ld_imask   = ld_imask_q;
  assign ld_mode    = ld_mode_q;
  assign irq_ack    = irq_ack_q;

endmodule

// File: tb/tb_trap_seq.sv
// -----------------------------------------------------------------------------
// tb_trap_seq -- directed bench for trap_seq.
// Three instances share one stimulus: d0 uses default parameters, d1 has
// EDGE=1 and d2 has PUSH_CAUSE=1. Inputs change and outputs are checked on
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_trap_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] irq;
  logic [3:0] irq_en;
  logic       imask;
  logic       boundary;
  logic       swint;
  logic       except;

  logic        d0_busy, d0_push_pc, d0_push_cause, d0_ld_pc_vec, d0_ld_imask, d0_ld_mode;
  logic [31:0] d0_vec;
  logic [7:0]  d0_cause;
  logic [3:0]  d0_irq_ack;
  logic        d1_busy, d1_push_pc, d1_push_cause, d1_ld_pc_vec, d1_ld_imask, d1_ld_mode;
  logic [31:0] d1_vec;
  logic [7:0]  d1_cause;
  logic [3:0]  d1_irq_ack;
  logic        d2_busy, d2_push_pc, d2_push_cause, d2_ld_pc_vec, d2_ld_imask, d2_ld_mode;
  logic [31:0] d2_vec;
  logic [7:0]  d2_cause;
  logic [3:0]  d2_irq_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_seq d0 (
    .clk(clk), .rst_n(rst_n), .irq(irq), .irq_en(irq_en), .imask(imask),
    .boundary(boundary), .swint(swint), .except(except),
    .busy(d0_busy), .push_pc(d0_push_pc), .push_cause(d0_push_cause),
    .ld_pc_vec(d0_ld_pc_vec), .vec(d0_vec), .cause(d0_cause),
    .ld_imask(d0_ld_imask), .ld_mode(d0_ld_mode), .irq_ack(d0_irq_ack)
  );

  trap_seq #(.EDGE(1'b1)) d1 (
    .clk(clk), .rst_n(rst_n), .irq(irq), .irq_en(irq_en), .imask(imask),
    .boundary(boundary), .swint(swint), .except(except),
    .busy(d1_busy), .push_pc(d1_push_pc), .push_cause(d1_push_cause),
    .ld_pc_vec(d1_ld_pc_vec), .vec(d1_vec), .cause(d1_cause),
    .ld_imask(d1_ld_imask), .ld_mode(d1_ld_mode), .irq_ack(d1_irq_ack)
  );

  trap_seq #(.PUSH_CAUSE(1'b1)) d2 (
    .clk(clk), .rst_n(rst_n), .irq(irq), .irq_en(irq_en), .imask(imask),
    .boundary(boundary), .swint(swint), .except(except),
    .busy(d2_busy), .push_pc(d2_push_pc), .push_cause(d2_push_cause),
    .ld_pc_vec(d2_ld_pc_vec), .vec(d2_vec), .cause(d2_cause),
    .ld_imask(d2_ld_imask), .ld_mode(d2_ld_mode), .irq_ack(d2_irq_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; irq = 4'h0; irq_en = 4'hF; imask = 1'b1;
    boundary = 1'b0; swint = 1'b0; except = 1'b0;
    step();
    // Reset state
    chk("rst_busy", d0_busy, 32'd0);
    chk("rst_push_pc", d0_push_pc, 32'd0);
    chk("rst_ld_pc_vec", d0_ld_pc_vec, 32'd0);
    chk("rst_vec", d0_vec, 32'd0);
    chk("rst_cause", d0_cause, 32'd0);
    chk("rst_irq_ack", d0_irq_ack, 32'd0);
    rst_n = 1'b1;

    // Default hw interrupt on line 2
    irq = 4'b0100; boundary = 1'b1;
    step();
    chk("hw_push_pc", d0_push_pc, 32'd1);
    chk("hw_busy", d0_busy, 32'd1);
    chk("hw_early_ld", d0_ld_pc_vec, 32'd0);
    boundary = 1'b0;
    step();
    chk("hw_ld_pc_vec", d0_ld_pc_vec, 32'd1);
    chk("hw_vec", d0_vec, 32'd3);
    chk("hw_cause", d0_cause, 32'h42);
    chk("hw_ack", d0_irq_ack, 32'h4);
    chk("hw_ld_imask", d0_ld_imask, 32'd1);
    chk("hw_ld_mode", d0_ld_mode, 32'd1);
    chk("hw_push_pc_off", d0_push_pc, 32'd0);
    chk("hw_no_push_cause", d0_push_cause, 32'd0);
    irq = 4'b0000;
    step();
    chk("hw_idle_busy", d0_busy, 32'd0);
    chk("hw_idle_ack", d0_irq_ack, 32'd0);
    chk("hw_vec_hold", d0_vec, 32'd3);

    // Priority: except over swint over hw; boundary ignored while busy
    irq = 4'hF; except = 1'b1; swint = 1'b1; boundary = 1'b1;
    step();
    chk("pri_push_pc", d0_push_pc, 32'd1);
    except = 1'b0; swint = 1'b0;
    step();
    chk("pri_vec", d0_vec, 32'd6);
    chk("pri_cause", d0_cause, 32'hC0);
    chk("pri_ld_imask", d0_ld_imask, 32'd0);
    chk("pri_ld_mode", d0_ld_mode, 32'd1);
    chk("pri_ack", d0_irq_ack, 32'd0);
    boundary = 1'b0; irq = 4'h0;
    step();
    chk("pri_idle", d0_busy, 32'd0);
    swint = 1'b1; boundary = 1'b1;
    step();
    chk("sw_push_pc", d0_push_pc, 32'd1);
    swint = 1'b0; boundary = 1'b0;
    step();
    chk("sw_vec", d0_vec, 32'd5);
    chk("sw_cause", d0_cause, 32'h80);
    chk("sw_ld_imask", d0_ld_imask, 32'd1);
    step();

    // Masking by imask, then acceptance
    imask = 1'b0; irq = 4'b0001; boundary = 1'b1;
    step();
    chk("mask_busy", d0_busy, 32'd0);
    chk("mask_push_pc", d0_push_pc, 32'd0);
    imask = 1'b1;
    step();
    chk("unmask_push_pc", d0_push_pc, 32'd1);
    boundary = 1'b0;
    step();
    chk("unmask_vec", d0_vec, 32'd1);
    chk("unmask_cause", d0_cause, 32'h40);
    chk("unmask_ack", d0_irq_ack, 32'h1);
    irq = 4'h0;
    step();

    // Per-line enable and lowest-index win
    irq_en = 4'b1110; irq = 4'b1011; boundary = 1'b1;
    step();
    boundary = 1'b0;
    step();
    chk("en_vec", d0_vec, 32'd2);
    chk("en_cause", d0_cause, 32'h41);
    chk("en_ack", d0_irq_ack, 32'h2);
    irq = 4'h0; irq_en = 4'hF;
    step();

    // EDGE=1: pulse latched while busy, then serviced and cleared
    do_reset();
    chk("e_idle", d1_busy, 32'd0);
    swint = 1'b1; boundary = 1'b1;
    step();
    chk("e_sw_push", d1_push_pc, 32'd1);
    swint = 1'b0; boundary = 1'b0; irq = 4'b0010;
    step();
    chk("e_sw_vec", d1_vec, 32'd5);
    irq = 4'b0000;
    step();
    chk("e_idle2", d1_busy, 32'd0);
    boundary = 1'b1;
    step();
    chk("e_pend_push", d1_push_pc, 32'd1);
    boundary = 1'b0;
    step();
    chk("e_vec", d1_vec, 32'd2);
    chk("e_ack", d1_irq_ack, 32'h2);
    chk("e_cause", d1_cause, 32'h41);
    step();
    boundary = 1'b1;
    step();
    chk("e_cleared", d1_busy, 32'd0);
    boundary = 1'b0;

    // EDGE=1: new edge in the ack cycle keeps the line pending
    irq = 4'b0010;
    step();
    irq = 4'b0000; boundary = 1'b1;
    step();
    chk("ew_push", d1_push_pc, 32'd1);
    boundary = 1'b0;
    step();
    chk("ew_ack", d1_irq_ack, 32'h2);
    irq = 4'b0010;
    step();
    chk("ew_idle", d1_busy, 32'd0);
    irq = 4'b0000; boundary = 1'b1;
    step();
    chk("ew_repush", d1_push_pc, 32'd1);
    boundary = 1'b0;
    step();
    chk("ew_vec", d1_vec, 32'd2);
    step();

    // PUSH_CAUSE=1 sequence against default instance
    do_reset();
    swint = 1'b1; boundary = 1'b1;
    step();
    chk("pc_push_pc", d2_push_pc, 32'd1);
    chk("pc_no_cause_yet", d2_push_cause, 32'd0);
    swint = 1'b0; boundary = 1'b0;
    step();
    chk("pc_push_cause", d2_push_cause, 32'd1);
    chk("pc_cause", d2_cause, 32'h80);
    chk("pc_no_ld_yet", d2_ld_pc_vec, 32'd0);
    chk("pc_busy", d2_busy, 32'd1);
    chk("d0_ld_pc_vec", d0_ld_pc_vec, 32'd1);
    chk("d0_no_push_cause", d0_push_cause, 32'd0);
    step();
    chk("pc_ld_pc_vec", d2_ld_pc_vec, 32'd1);
    chk("pc_vec", d2_vec, 32'd5);
    chk("pc_ld_imask", d2_ld_imask, 32'd1);
    chk("pc_cause_off", d2_push_cause, 32'd0);
    step();
    chk("pc_idle", d2_busy, 32'd0);

    // Asynchronous reset in PUSH_PC
    except = 1'b1; boundary = 1'b1;
    step();
    chk("ar_push_pc", d0_push_pc, 32'd1);
    except = 1'b0; boundary = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_push_pc_off", d0_push_pc, 32'd0);
    chk("ar_busy", d0_busy, 32'd0);
    chk("ar_vec", d0_vec, 32'd0);
    chk("ar_cause", d0_cause, 32'd0);
    step();
    chk("ar_no_ld", d0_ld_pc_vec, 32'd0);
    rst_n = 1'b1;
    except = 1'b1; boundary = 1'b1;
    step();
    chk("ar2_push_pc", d0_push_pc, 32'd1);
    except = 1'b0; boundary = 1'b0;
    step();
    chk("ar2_ld", d0_ld_pc_vec, 32'd1);
    chk("ar2_vec", d0_vec, 32'd6);
    chk("ar2_cause", d0_cause, 32'hC0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
